// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types for the scoreboard hazard unit: latency classes, forwarding selects
// and the busy-counter width.
package hazard_pkg;

  localparam int BUSY_W = 3;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_VEC  = 2'd2
  } lat_class_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Cycles until a result of this class can be forwarded; unknown encodings behave as ALU.
  function automatic logic [BUSY_W-1:0] lat_cycles(input lat_class_t     c,
                                                    input logic [BUSY_W-1:0] load_lat,
                                                    input logic [BUSY_W-1:0] vec_lat);
    case (c)
      LAT_LOAD: lat_cycles = load_lat;
      LAT_VEC:  lat_cycles = vec_lat;
      default:  lat_cycles = BUSY_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_busy_counter_bank.sv
// Per-register pending-write counters for one register file: one set port,
// two source read ports and a destination read port.
module busy_counter_bank
  import hazard_pkg::*;
#(
  parameter int ADDRESSWIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_en,
  input  logic [ADDRESSWIDTH-1:0] set_addr,
  input  logic [BUSY_W-1:0]       set_val,
  input  logic [ADDRESSWIDTH-1:0] rd1_addr,
  input  logic [ADDRESSWIDTH-1:0] rd2_addr,
  input  logic [ADDRESSWIDTH-1:0] rdw_addr,
  output logic [BUSY_W-1:0]       rd1_busy,
  output logic [BUSY_W-1:0]       rd2_busy,
  output logic [BUSY_W-1:0]       rdw_busy
);

  localparam int NREG = 2 ** ADDRESSWIDTH;

  logic [BUSY_W-1:0] busy_q [NREG];
  logic [BUSY_W-1:0] busy_d [NREG];

  // Every counter counts down and sticks at zero; a new issue overrides the decrement.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      busy_d[i] = (busy_q[i] != '0) ? busy_q[i] - BUSY_W'(1) : '0;
    end
    if (set_en) begin
      busy_d[set_addr] = set_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        busy_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        busy_q[i] <= busy_d[i];
      end
    end
  end

  assign rd1_busy = busy_q[rd1_addr];
  assign rd2_busy = busy_q[rd2_addr];
  assign rdw_busy = busy_q[rdw_addr];

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard hazard unit for the scalar+vector pipeline: stall/flush control and E-stage
// forwarding selects. Optional HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int ADDRESSWIDTH = 4,
  parameter int LOADLATENCY  = 2,
  parameter int VECLATENCY   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issueValidD,
  input  logic                    isScalarD,
  input  logic                    isScalarE,
  input  logic                    isScalarM,
  input  logic                    isScalarWB,
  input  logic                    isVecScalarOpD,
  input  logic                    isVecScalarOpE,
  input  logic                    writeEnableD,
  input  lat_class_t              latClassD,
  input  logic [ADDRESSWIDTH-1:0] reg1AddrD,
  input  logic [ADDRESSWIDTH-1:0] reg2AddrD,
  input  logic [ADDRESSWIDTH-1:0] writeAddrD,
  input  logic [ADDRESSWIDTH-1:0] reg1AddrE,
  input  logic [ADDRESSWIDTH-1:0] reg2AddrE,
  input  logic [ADDRESSWIDTH-1:0] writeAddrM,
  input  logic [ADDRESSWIDTH-1:0] writeAddrWB,
  input  logic                    writeEnableM,
  input  logic                    writeEnableWB,
  input  logic                    takeBranchE,
  output fwd_sel_t                fwd1ScalarE,
  output fwd_sel_t                fwd2ScalarE,
  output fwd_sel_t                fwd1VectorE,
  output fwd_sel_t                fwd2VectorE,
  output logic                    stallF,
  output logic                    stallD,
  output logic                    flushD,
  output logic                    flushE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             stallCount,
  output logic [31:0]             flushCount
`endif
);

  localparam logic [BUSY_W-1:0] LOAD_LAT = BUSY_W'(LOADLATENCY);
  localparam logic [BUSY_W-1:0] VEC_LAT  = BUSY_W'(VECLATENCY);

  logic [BUSY_W-1:0] s_rd1_busy, s_rd2_busy, s_dst_busy;
  logic [BUSY_W-1:0] v_rd1_busy, v_rd2_busy, v_dst_busy;
  logic [BUSY_W-1:0] src1_busy, src2_busy, dst_busy, own_lat;
  logic              src2_scalar_d, raw_hazard, waw_hazard, hazard, issue;
  logic              s_set_en, v_set_en;

  // Issue handshake: issueValidD is the valid, ready is (!stallD & !takeBranchE); the
  // D instruction is recorded into the scoreboard only on a cycle where both are high.
  assign src2_scalar_d = isScalarD | isVecScalarOpD;
  assign src1_busy     = isScalarD ? s_rd1_busy : v_rd1_busy;
  assign src2_busy     = src2_scalar_d ? s_rd2_busy : v_rd2_busy;
  assign dst_busy      = isScalarD ? s_dst_busy : v_dst_busy;
  assign own_lat       = lat_cycles(latClassD, LOAD_LAT, VEC_LAT);

  assign raw_hazard = issueValidD & ((src1_busy > BUSY_W'(1)) | (src2_busy > BUSY_W'(1)));
  assign waw_hazard = issueValidD & writeEnableD & (dst_busy > own_lat);
  assign hazard     = raw_hazard | waw_hazard;
  assign issue      = issueValidD & ~hazard & ~takeBranchE;
  assign s_set_en   = issue & writeEnableD & isScalarD;
  assign v_set_en   = issue & writeEnableD & ~isScalarD;

  busy_counter_bank #(.ADDRESSWIDTH(ADDRESSWIDTH)) u_scalar_bank (
    .clk      (clk),
    .reset    (reset),
    .set_en   (s_set_en),
    .set_addr (writeAddrD),
    .set_val  (own_lat),
    .rd1_addr (reg1AddrD),
    .rd2_addr (reg2AddrD),
    .rdw_addr (writeAddrD),
    .rd1_busy (s_rd1_busy),
    .rd2_busy (s_rd2_busy),
    .rdw_busy (s_dst_busy)
  );

  busy_counter_bank #(.ADDRESSWIDTH(ADDRESSWIDTH)) u_vector_bank (
    .clk      (clk),
    .reset    (reset),
    .set_en   (v_set_en),
    .set_addr (writeAddrD),
    .set_val  (own_lat),
    .rd1_addr (reg1AddrD),
    .rd2_addr (reg2AddrD),
    .rdw_addr (writeAddrD),
    .rd1_busy (v_rd1_busy),
    .rd2_busy (v_rd2_busy),
    .rdw_busy (v_dst_busy)
  );

  // A taken branch squashes D, so it overrides any stall; reset forces every output low.
  assign stallF = reset & hazard & ~takeBranchE;
  assign stallD = reset & hazard & ~takeBranchE;
  assign flushD = reset & takeBranchE;
  assign flushE = reset & (hazard | takeBranchE);

  function automatic fwd_sel_t fwd_pick(input logic [ADDRESSWIDTH-1:0] addr,
                                        input logic                    bank_scalar);
    if (writeEnableM && (isScalarM == bank_scalar) && (writeAddrM == addr)) begin
      fwd_pick = FWD_MEM;
    end else if (writeEnableWB && (isScalarWB == bank_scalar) && (writeAddrWB == addr)) begin
      fwd_pick = FWD_WB;
    end else begin
      fwd_pick = FWD_RF;
    end
  endfunction

  logic src2_scalar_e;
  assign src2_scalar_e = isScalarE | isVecScalarOpE;

  always_comb begin
    fwd1ScalarE = FWD_RF;
    fwd2ScalarE = FWD_RF;
    fwd1VectorE = FWD_RF;
    fwd2VectorE = FWD_RF;
    if (reset) begin
      if (isScalarE) fwd1ScalarE = fwd_pick(reg1AddrE, 1'b1);
      else           fwd1VectorE = fwd_pick(reg1AddrE, 1'b0);
      if (src2_scalar_e) fwd2ScalarE = fwd_pick(reg2AddrE, 1'b1);
      else               fwd2VectorE = fwd_pick(reg2AddrE, 1'b0);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallD && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flushD && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: load-use, vector latency, WAW, forwarding
// priority/banking, branch-over-stall and reset-mid-stall scenarios.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  localparam int AW = 4;

  logic          clk;
  logic          reset;
  logic          issueValidD, isScalarD, isScalarE, isScalarM, isScalarWB;
  logic          isVecScalarOpD, isVecScalarOpE, writeEnableD;
  lat_class_t    latClassD;
  logic [AW-1:0] reg1AddrD, reg2AddrD, writeAddrD, reg1AddrE, reg2AddrE;
  logic [AW-1:0] writeAddrM, writeAddrWB;
  logic          writeEnableM, writeEnableWB, takeBranchE;
  fwd_sel_t      fwd1ScalarE, fwd2ScalarE, fwd1VectorE, fwd2VectorE;
  logic          stallF, stallD, flushD, flushE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stallCount, flushCount;
`endif

  int vectors;
  int miscompares;

  hazard_scoreboard_unit #(.ADDRESSWIDTH(AW), .LOADLATENCY(2), .VECLATENCY(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .issueValidD    (issueValidD),
    .isScalarD      (isScalarD),
    .isScalarE      (isScalarE),
    .isScalarM      (isScalarM),
    .isScalarWB     (isScalarWB),
    .isVecScalarOpD (isVecScalarOpD),
    .isVecScalarOpE (isVecScalarOpE),
    .writeEnableD   (writeEnableD),
    .latClassD      (latClassD),
    .reg1AddrD      (reg1AddrD),
    .reg2AddrD      (reg2AddrD),
    .writeAddrD     (writeAddrD),
    .reg1AddrE      (reg1AddrE),
    .reg2AddrE      (reg2AddrE),
    .writeAddrM     (writeAddrM),
    .writeAddrWB    (writeAddrWB),
    .writeEnableM   (writeEnableM),
    .writeEnableWB  (writeEnableWB),
    .takeBranchE    (takeBranchE),
    .fwd1ScalarE    (fwd1ScalarE),
    .fwd2ScalarE    (fwd2ScalarE),
    .fwd1VectorE    (fwd1VectorE),
    .fwd2VectorE    (fwd2VectorE),
    .stallF         (stallF),
    .stallD         (stallD),
    .flushD         (flushD),
    .flushE         (flushE)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stallCount     (stallCount),
    .flushCount     (flushCount)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic v, input logic sc, input logic vs, input logic we,
                         input lat_class_t lc, input int r1, input int r2, input int wa);
    issueValidD    = v;
    isScalarD      = sc;
    isVecScalarOpD = vs;
    writeEnableD   = we;
    latClassD      = lc;
    reg1AddrD      = AW'(r1);
    reg2AddrD      = AW'(r2);
    writeAddrD     = AW'(wa);
  endtask

  task automatic drive_e(input logic sc, input logic vs, input int r1, input int r2);
    isScalarE      = sc;
    isVecScalarOpE = vs;
    reg1AddrE      = AW'(r1);
    reg2AddrE      = AW'(r2);
  endtask

  task automatic drive_mw(input logic we_m, input logic sc_m, input int a_m,
                          input logic we_wb, input logic sc_wb, input int a_wb);
    writeEnableM  = we_m;
    isScalarM     = sc_m;
    writeAddrM    = AW'(a_m);
    writeEnableWB = we_wb;
    isScalarWB    = sc_wb;
    writeAddrWB   = AW'(a_wb);
  endtask

  task automatic settle();
    #1;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    takeBranchE = 1'b1;
    drive_d(1'b0, 1'b1, 1'b0, 1'b0, LAT_ALU, 0, 0, 0);
    drive_e(1'b1, 1'b0, 1, 2);
    drive_mw(1'b1, 1'b1, 1, 1'b1, 1'b1, 2);
    settle();
    // Reset: every output held low even with a branch and matching M/WB writes
    chk("rst_stallF", {31'd0, stallF}, 32'd0);
    chk("rst_stallD", {31'd0, stallD}, 32'd0);
    chk("rst_flushD", {31'd0, flushD}, 32'd0);
    chk("rst_flushE", {31'd0, flushE}, 32'd0);
    chk("rst_fwd1S", {30'd0, fwd1ScalarE}, 32'd0);
    chk("rst_fwd2S", {30'd0, fwd2ScalarE}, 32'd0);
    tick();
    tick();
    reset       = 1'b1;
    takeBranchE = 1'b0;
    drive_e(1'b1, 1'b0, 0, 0);
    drive_mw(1'b0, 1'b1, 0, 1'b0, 1'b1, 0);
    settle();

    // Load-use: LOAD r3, then a reader of r3 stalls exactly one cycle
    drive_d(1'b1, 1'b1, 1'b0, 1'b1, LAT_LOAD, 0, 0, 3);
    settle();
    chk("ld_issue_stall", {31'd0, stallD}, 32'd0);
    tick();
    drive_d(1'b1, 1'b1, 1'b0, 1'b1, LAT_ALU, 3, 0, 6);
    settle();
    chk("ld_use_stallD", {31'd0, stallD}, 32'd1);
    chk("ld_use_stallF", {31'd0, stallF}, 32'd1);
    chk("ld_use_flushE", {31'd0, flushE}, 32'd1);
    chk("ld_use_flushD", {31'd0, flushD}, 32'd0);
    tick();
    chk("ld_use_release", {31'd0, stallD}, 32'd0);
    chk("ld_use_flushE_rel", {31'd0, flushE}, 32'd0);
    tick();
    drive_d(1'b0, 1'b1, 1'b0, 1'b0, LAT_ALU, 0, 0, 0);
    drive_e(1'b1, 1'b0, 3, 0);
    drive_mw(1'b1, 1'b1, 3, 1'b0, 1'b1, 0);
    settle();
    chk("ld_fwd1S_mem", {30'd0, fwd1ScalarE}, 32'd2);
    chk("ld_fwd1V_rf", {30'd0, fwd1VectorE}, 32'd0);
    drive_e(1'b1, 1'b0, 0, 0);
    drive_mw(1'b0, 1'b1, 0, 1'b0, 1'b1, 0);

    // Vector latency 3: reader of v2 stalls two cycles
    drive_d(1'b1, 1'b0, 1'b0, 1'b1, LAT_VEC, 0, 0, 2);
    settle();
    chk("vec_issue_stall", {31'd0, stallD}, 32'd0);
    tick();
    drive_d(1'b1, 1'b0, 1'b0, 1'b1, LAT_VEC, 1, 2, 7);
    settle();
    chk("vec_stall_c1", {31'd0, stallD}, 32'd1);
    chk("vec_flushE_c1", {31'd0, flushE}, 32'd1);
    tick();
    chk("vec_stall_c2", {31'd0, stallD}, 32'd1);
    chk("vec_flushE_c2", {31'd0, flushE}, 32'd1);
    tick();
    chk("vec_release", {31'd0, stallD}, 32'd0);
    chk("vec_flushE_rel", {31'd0, flushE}, 32'd0);
    tick();

    // WAW on v7 (busy 3): an ALU write must wait, a VEC write may go
    drive_d(1'b1, 1'b0, 1'b0, 1'b1, LAT_ALU, 0, 0, 7);
    settle();
    chk("waw_alu_stall", {31'd0, stallD}, 32'd1);
    drive_d(1'b1, 1'b0, 1'b0, 1'b1, LAT_VEC, 0, 0, 7);
    settle();
    chk("waw_vec_nostall", {31'd0, stallD}, 32'd0);
    issueValidD = 1'b0;
    tick();

    // Scalar ALU r5 feeding a vector-scalar op on src2
    drive_d(1'b1, 1'b1, 1'b0, 1'b1, LAT_ALU, 0, 0, 5);
    tick();
    drive_d(1'b1, 1'b0, 1'b1, 1'b0, LAT_ALU, 0, 5, 0);
    settle();
    chk("vs_nostall", {31'd0, stallD}, 32'd0);
    issueValidD = 1'b0;
    drive_e(1'b0, 1'b1, 5, 5);
    drive_mw(1'b1, 1'b1, 5, 1'b0, 1'b1, 0);
    settle();
    chk("vs_fwd2S_mem", {30'd0, fwd2ScalarE}, 32'd2);
    chk("vs_fwd2V_rf", {30'd0, fwd2VectorE}, 32'd0);
    chk("vs_fwd1V_rf", {30'd0, fwd1VectorE}, 32'd0);
    chk("vs_fwd1S_rf", {30'd0, fwd1ScalarE}, 32'd0);

    // Forwarding priority and banking
    drive_e(1'b1, 1'b0, 4, 9);
    drive_mw(1'b1, 1'b1, 4, 1'b1, 1'b1, 4);
    settle();
    chk("prio_m_over_wb", {30'd0, fwd1ScalarE}, 32'd2);
    drive_mw(1'b0, 1'b1, 4, 1'b1, 1'b1, 4);
    settle();
    chk("wb_only_scalar", {30'd0, fwd1ScalarE}, 32'd1);
    drive_mw(1'b0, 1'b1, 4, 1'b1, 1'b0, 4);
    settle();
    chk("wb_vec_no_sfwd", {30'd0, fwd1ScalarE}, 32'd0);
    drive_mw(1'b0, 1'b1, 4, 1'b1, 1'b1, 9);
    settle();
    chk("wb_src2_scalar", {30'd0, fwd2ScalarE}, 32'd1);
    chk("wb_src2_src1_rf", {30'd0, fwd1ScalarE}, 32'd0);
    drive_e(1'b0, 1'b0, 4, 9);
    drive_mw(1'b0, 1'b1, 4, 1'b1, 1'b0, 4);
    settle();
    chk("wb_vec_fwd1V", {30'd0, fwd1VectorE}, 32'd1);
    chk("wb_vec_fwd1S_rf", {30'd0, fwd1ScalarE}, 32'd0);
    drive_e(1'b1, 1'b0, 0, 0);
    drive_mw(1'b0, 1'b1, 0, 1'b0, 1'b1, 0);
    tick();

    // Branch taken during a load-use stall
    drive_d(1'b1, 1'b1, 1'b0, 1'b1, LAT_LOAD, 0, 0, 3);
    tick();
    drive_d(1'b1, 1'b1, 1'b0, 1'b1, LAT_VEC, 3, 0, 8);
    takeBranchE = 1'b1;
    settle();
    chk("br_flushD", {31'd0, flushD}, 32'd1);
    chk("br_flushE", {31'd0, flushE}, 32'd1);
    chk("br_stallF", {31'd0, stallF}, 32'd0);
    chk("br_stallD", {31'd0, stallD}, 32'd0);
    tick();
    takeBranchE = 1'b0;
    drive_d(1'b1, 1'b1, 1'b0, 1'b0, LAT_ALU, 8, 8, 0);
    settle();
    chk("br_no_counter", {31'd0, stallD}, 32'd0);
    chk("br_flushD_rel", {31'd0, flushD}, 32'd0);
    issueValidD = 1'b0;
    tick();

    // Reset asserted in the middle of a vector stall
    drive_d(1'b1, 1'b0, 1'b0, 1'b1, LAT_VEC, 0, 0, 2);
    tick();
    drive_d(1'b1, 1'b0, 1'b0, 1'b0, LAT_ALU, 2, 0, 0);
    settle();
    chk("rstmid_pre_stall", {31'd0, stallD}, 32'd1);
    reset = 1'b0;
    settle();
    chk("rstmid_stallD", {31'd0, stallD}, 32'd0);
    chk("rstmid_stallF", {31'd0, stallF}, 32'd0);
    chk("rstmid_flushE", {31'd0, flushE}, 32'd0);
    reset = 1'b1;
    settle();
    chk("rstmid_after_stall", {31'd0, stallD}, 32'd0);
    tick();
    issueValidD = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
